// File: rtl/rv32_muldiv_pkg.sv
// Shared definitions for the iterative RV32 M-extension unit:
// funct3 operation codes and the controller state encoding.
package rv32_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rv32_muldiv_step.sv
// One radix-2 iteration on the {high, low} accumulator.
// Multiply: conditional add of the multiplicand into the high half, then a
// right shift that pulls the consumed multiplier bit out of the low half.
// Divide: restoring shift-subtract; the low half shifts the dividend out and
// the quotient bit in, the high half holds the partial remainder.
module rv32_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                i_is_div,
  input  logic [2*XLEN-1:0]   i_acc,
  input  logic [XLEN-1:0]     i_opnd,
  output logic [2*XLEN-1:0]   o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_top;
  logic [XLEN:0] w_trial;

  // Single iteration for either operation class, selected by i_is_div
  always_comb begin
    w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // Partial remainder shifted left with the next dividend bit; needs XLEN+1
    // bits because the remainder may be up to divisor-1 before the shift.
    w_top   = i_acc[2*XLEN-1:XLEN-1];
    w_trial = w_top - {1'b0, i_opnd};
    if (i_is_div) begin
      if (!w_trial[XLEN]) begin
        o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end else begin
        o_acc = {w_top[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv32_muldiv.sv
// Iterative M-extension unit: operands are converted to magnitudes on accept,
// XLEN unsigned shift-add / shift-subtract steps run in BUSY, and the sign is
// restored in FIX. Divide-by-zero and signed overflow bypass straight to DONE.
module rv32_muldiv
  import rv32_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  state_e            w_next;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_step_acc;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_fix_res;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand decode on the request bus: signedness, magnitudes, special cases
  always_comb begin
    w_is_div   = op[2];
    w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    w_a_neg    = w_a_signed & a[XLEN-1];
    w_b_neg    = w_b_signed & b[XLEN-1];
    w_a_mag    = neg_if(w_a_neg, a);
    w_b_mag    = neg_if(w_b_neg, b);
    // Remainder follows the dividend; everything else follows the sign product
    w_neg      = (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = w_is_div && (b == '0);
    w_ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
    w_special  = w_div_zero || w_ovf;
    if (op[1]) begin
      w_special_res = w_div_zero ? a : '0;
    end else begin
      w_special_res = w_div_zero ? '1 : a;
    end
  end

  rv32_muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_is_div(r_op[2]),
    .i_acc   (r_acc),
    .i_opnd  (r_opnd),
    .o_acc   (w_step_acc)
  );

  // Sign correction and word selection applied in FIX
  always_comb begin
    w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = neg_if(r_neg, r_acc[XLEN-1:0]);
      OP_REM, OP_REMU:              w_fix_res = neg_if(r_neg, r_acc[2*XLEN-1:XLEN]);
      default:                      w_fix_res = '0;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_special ? S_DONE : S_BUSY;
      end
      S_BUSY: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign result = r_result;

  // Datapath registers: capture on accept, iterate in BUSY, finalise in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op   <= op;
          r_neg  <= w_neg;
          r_cnt  <= CW'(XLEN-1);
          r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          r_opnd <= w_is_div ? w_b_mag : w_a_mag;
          if (w_special) r_result <= w_special_res;
        end
        S_BUSY: begin
          r_acc <= w_step_acc;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv32_muldiv.md
Name: rv32_muldiv

Overview:
- Iterative multi-cycle M-extension unit for the RV32I core. Sits beside the combinational ALU in execute.
- Accepts one operation via a valid/ready request handshake and returns one 32-bit result via a valid/ready response handshake.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU radix-2, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- op  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  result value.

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, result=0, counter=0, internal registers cleared. in_ready=1 while in IDLE, including during reset.
- Reset mid-operation aborts the operation immediately; no result is ever produced for it.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - in_valid&in_ready registers op/a/b and takes operand magnitudes (signed per op).
  - Goes to BUSY with counter=XLEN-1.
  - Special divide cases go directly to DONE instead.
- BUSY:
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle.
  - Counter decrements; at 0 go to FIX.
  - in_ready=0.
- FIX: apply sign correction, select low/high product word or quotient/remainder, register result. Go to DONE.
- DONE: out_valid=1, result held stable until out_valid&out_ready, then IDLE.
- No accept in the same cycle as a response; the next request is accepted one cycle later in IDLE.
- Latency: acceptance edge to out_valid = XLEN+2 cycles (34 for XLEN=32). Special cases: 1 cycle.
- Special cases (RISC-V defined, no trap):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow a=0x80000000, b=-1: DIV -> 0x80000000; REM -> 0.
- Signs:
  - MULH: both operands signed. MULHSU: a signed, b unsigned.
  - DIV/REM: quotient negative iff signs differ and b!=0; remainder takes the sign of a.
- Product accumulates in a 2*XLEN register. MUL returns bits [XLEN-1:0]; MULH* return [2*XLEN-1:XLEN].
- out_ready while not out_valid: ignored. in_valid outside IDLE: ignored; the operands are not sampled.
- a/b/op need not be held after acceptance.

Decomposition:
- Package rv32_muldiv_pkg: op encoding constants (funct3 values); state enum (IDLE/BUSY/FIX/DONE).
- One sub-module: rv32_muldiv_step. Combinational single-iteration datapath (add-or-pass for mul, trial subtract + quotient bit for div), instantiated once.
- FSM, counter, handshakes and sign fix-up stay in the top module.

Test Plan:
- MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 34 cycles after acceptance; in_ready low throughout.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100 b=7 -> 14. REMU -> 2.
- DIVU a=5 b=0 -> 0xFFFFFFFF, and REMU -> 5, both 1 cycle after acceptance. DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: out_ready held low 10 cycles after out_valid -> result and out_valid stable, in_ready=0. After the handshake, in_ready=1 next cycle and back-to-back requests complete in order.
- Async reset asserted mid-BUSY (cycle 10) -> out_valid=0, result=0 immediately. After release, no stale result appears and a new MUL 3*4 returns 12.
